image_write: RTL
================

IMAGE_WRITE -- requirements
Module: image_write

Interface
REQ-001 SHALL have parameter CFG_DWIDTH, default 32, config data width.
REQ-002 SHALL have parameter CFG_AWIDTH, default 5, config address width.
REQ-003 SHALL have parameter GROUP_NB, default 4, pixels per memory word.
REQ-004 SHALL have parameter IMG_WIDTH, default 16, bits per pixel.
REQ-005 SHALL have parameter MEM_AWIDTH, default 16, image memory address width.
REQ-006 SHALL have ports, one per line:
 clk  in  1  single clock, all logic on rising edge;
 rst  in  1  reset, asynchronous, active-high;
 cfg_data  in  CFG_DWIDTH  config write data;
 cfg_addr  in  CFG_AWIDTH  config register select;
 cfg_valid  in  1  config write strobe;
 next  in  1  latch shadow cfg and start a segment;
 image_bus  in  GROUP_NB*IMG_WIDTH  result pixel group;
 image_last  in  1  producer marks final beat of segment;
 image_val  in  1  beat valid;
 image_rdy  out  1  block accepts beat;
 wr_val  out  1  memory write strobe;
 wr_addr  out  MEM_AWIDTH  memory write address;
 wr_data  out  GROUP_NB*IMG_WIDTH  memory write data;
 done  out  1  one-cycle pulse, segment fully written;
 err  out  1  sticky last-framing error.

Function
REQ-007 SHALL capture cfg_data into shadow registers when cfg_valid and cfg_addr match: CFG_IW_IMG_W (bits 31:0 width), CFG_IW_IMG_DH (31:16 depth, 15:0 height), CFG_IW_BASE (MEM_AWIDTH-1:0 start address).
REQ-008 SHALL treat width, height, depth as zero-indexed: cfg 0 means 1; segment length N = W*H*D beats.
REQ-009 SHALL use one-hot states RESET, CONFIG, ACTIVE, DONE; RESET->CONFIG unconditionally; CONFIG->ACTIVE two cycles after next is sampled in CONFIG; ACTIVE->DONE on acceptance of beat N; DONE->CONFIG unconditionally.
REQ-010 SHALL honour next only in CONFIG; next in any other state is ignored and shadow writes then only affect the following segment.
REQ-011 SHALL drive image_rdy = 1 only in ACTIVE; a beat is accepted when image_val & image_rdy.
REQ-012 SHALL, one cycle after each accepted beat, assert wr_val for exactly one cycle with wr_data = accepted image_bus and wr_addr = base + beat index.
REQ-013 SHALL count depth innermost, then width, then height (d_cnt, w_cnt, h_cnt), wrapping each at its zero-indexed maximum; final beat is all three at maximum.
REQ-014 SHALL compute wr_addr modulo 2^MEM_AWIDTH; base + index overflow wraps silently.
REQ-015 SHALL pulse done for one cycle in DONE, coincident with wr_val of beat N.
REQ-016 SHALL hold wr_val low and counters static while image_val is low in ACTIVE (bubbles allowed, no timeout).
REQ-017 SHALL set err when an accepted beat has image_last high but is not beat N, or is beat N with image_last low; err clears only when next is honoured.
REQ-018 SHALL NOT alter state or counters on err; segment completion is decided solely by count.

Reset
REQ-019 SHALL on rst, asynchronously, enter RESET, zero all counters, and drive image_rdy=0, wr_val=0, done=0, err=0, wr_addr=0, wr_data=0.
REQ-020 SHALL abandon an in-progress segment on rst mid-ACTIVE; no further wr_val until a new next; shadow cfg registers are not reset.

Configuration
REQ-021 SHALL, with IMAGE_WRITE_LAST_CHECK_EN defined, implement REQ-017; without it err is tied 0 and image_last is unused.

Structure
REQ-022 SHALL take CFG_IW_IMG_W, CFG_IW_IMG_DH, CFG_IW_BASE from the shared cfg_parameters package alongside existing CFG_IR_* constants; state encodings stay local.
REQ-023 SHALL be a single module; no sub-module.

Verification
REQ-024 cfg W=1,H=1,D=0 (2x2x1), base 0x0100, next, 4 continuous beats -> wr_addr 0x0100..0x0103 one cycle after each accept, done with 4th write, back to CONFIG.
REQ-025 same cfg, image_val toggled 1,0,0,1,... -> exactly 4 writes, addresses contiguous, no write on bubble cycles.
REQ-026 base 0xFFFE, 4 beats -> wr_addr 0xFFFE,0xFFFF,0x0000,0x0001.
REQ-027 image_last on beat 2 of 4 (macro defined) -> err=1 from next cycle, all 4 writes still issued, err clears on next honoured; macro undefined -> err stays 0.
REQ-028 rst asserted after beat 2 -> wr_val, image_rdy, done low immediately; following next with new cfg writes from new base index 0.
REQ-029 next pulsed during ACTIVE -> ignored; segment completes with original cfg.

Source files
------------

// File: rtl/cfg_parameters.sv
// Shared configuration register map for the image reader/writer blocks.
// Holds the register select codes and the field widths of the image geometry words.
package cfg_parameters;

    // Image reader registers
    localparam int unsigned CFG_IR_IMG_W  = 0;
    localparam int unsigned CFG_IR_IMG_DH = 1;
    localparam int unsigned CFG_IR_BASE   = 2;

    // Image writer registers
    localparam int unsigned CFG_IW_IMG_W  = 3;
    localparam int unsigned CFG_IW_IMG_DH = 4;
    localparam int unsigned CFG_IW_BASE   = 5;

    // Geometry field widths: width word is full 32 bits, DH word packs depth[31:16], height[15:0]
    localparam int unsigned IMG_W_BITS = 32;
    localparam int unsigned IMG_H_BITS = 16;
    localparam int unsigned IMG_D_BITS = 16;

endpackage

// File: rtl/image_write.sv
// Streams pixel-group beats of one W*H*D segment into image memory at base + beat index.
// Optional framing check of image_last vs. beat count: define IMAGE_WRITE_LAST_CHECK_EN.
module image_write
    import cfg_parameters::*;
#(
    parameter int CFG_DWIDTH = 32,
    parameter int CFG_AWIDTH = 5,
    parameter int GROUP_NB   = 4,
    parameter int IMG_WIDTH  = 16,
    parameter int MEM_AWIDTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [CFG_DWIDTH-1:0]         cfg_data,
    input  logic [CFG_AWIDTH-1:0]         cfg_addr,
    input  logic                          cfg_valid,
    input  logic                          next,
    input  logic [GROUP_NB*IMG_WIDTH-1:0] image_bus,
    input  logic                          image_last,
    input  logic                          image_val,
    output logic                          image_rdy,
    output logic                          wr_val,
    output logic [MEM_AWIDTH-1:0]         wr_addr,
    output logic [GROUP_NB*IMG_WIDTH-1:0] wr_data,
    output logic                          done,
    output logic                          err
);

    typedef enum logic [3:0] {
        ST_RESET  = 4'b0001,
        ST_CONFIG = 4'b0010,
        ST_ACTIVE = 4'b0100,
        ST_DONE   = 4'b1000
    } state_e;

    state_e state_q, state_d;
    logic [1:0] launch_q, launch_d;

    logic [IMG_W_BITS-1:0] shd_w_q;
    logic [IMG_H_BITS-1:0] shd_h_q;
    logic [IMG_D_BITS-1:0] shd_d_q;
    logic [MEM_AWIDTH-1:0] shd_base_q;

    logic [IMG_W_BITS-1:0] w_max_q, w_cnt_q;
    logic [IMG_H_BITS-1:0] h_max_q, h_cnt_q;
    logic [IMG_D_BITS-1:0] d_max_q, d_cnt_q;
    logic [MEM_AWIDTH-1:0] base_q, idx_q;

    logic                          wr_val_q;
    logic [MEM_AWIDTH-1:0]         wr_addr_q;
    logic [GROUP_NB*IMG_WIDTH-1:0] wr_data_q;

    logic next_take;
    logic accept;
    logic last_beat;

    assign next_take = (state_q == ST_CONFIG) && next && (launch_q == 2'd0);
    assign accept    = image_val && image_rdy;
    assign last_beat = (d_cnt_q == d_max_q) && (w_cnt_q == w_max_q) && (h_cnt_q == h_max_q);

    // NOTE: shadow registers carry no reset so a mid-segment reset keeps the programmed geometry.
    always_ff @(posedge clk) begin
        if (cfg_valid) begin
            if (cfg_addr == CFG_AWIDTH'(CFG_IW_IMG_W)) begin
                shd_w_q <= cfg_data[31:0];
            end
            if (cfg_addr == CFG_AWIDTH'(CFG_IW_IMG_DH)) begin
                shd_d_q <= cfg_data[31:16];
                shd_h_q <= cfg_data[15:0];
            end
            if (cfg_addr == CFG_AWIDTH'(CFG_IW_BASE)) begin
                shd_base_q <= cfg_data[MEM_AWIDTH-1:0];
            end
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_RESET;
            launch_q <= 2'd0;
        end else begin
            state_q  <= state_d;
            launch_q <= launch_d;
        end
    end

    // Next-state logic; launch_q delays entry to ACTIVE by two cycles after next is honoured
    always_comb begin
        // NOTE: defaults first so every path assigns the outputs and no latch is inferred.
        state_d  = state_q;
        launch_d = 2'd0;
        if (next_take) begin
            launch_d = 2'd1;
        end else if (launch_q == 2'd1) begin
            launch_d = 2'd2;
        end
        unique case (state_q)
            ST_RESET:  state_d = ST_CONFIG;
            ST_CONFIG: if (launch_q == 2'd2) state_d = ST_ACTIVE;
            ST_ACTIVE: if (accept && last_beat) state_d = ST_DONE;
            ST_DONE:   state_d = ST_CONFIG;
            default:   state_d = ST_RESET;
        endcase
    end

    // Output logic
    always_comb begin
        image_rdy = 1'b0;
        done      = 1'b0;
        unique case (state_q)
            ST_ACTIVE: image_rdy = 1'b1;
            ST_DONE:   done      = 1'b1;
            default: ;
        endcase
    end

    // Segment geometry, beat counters and the registered memory write port
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_max_q   <= '0;
            h_max_q   <= '0;
            d_max_q   <= '0;
            base_q    <= '0;
            w_cnt_q   <= '0;
            h_cnt_q   <= '0;
            d_cnt_q   <= '0;
            idx_q     <= '0;
            wr_val_q  <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            wr_val_q <= accept;
            if (next_take) begin
                w_max_q <= shd_w_q;
                h_max_q <= shd_h_q;
                d_max_q <= shd_d_q;
                base_q  <= shd_base_q;
                w_cnt_q <= '0;
                h_cnt_q <= '0;
                d_cnt_q <= '0;
                idx_q   <= '0;
            end else if (accept) begin
                wr_addr_q <= base_q + idx_q;
                wr_data_q <= image_bus;
                idx_q     <= idx_q + 1'b1;
                if (d_cnt_q == d_max_q) begin
                    d_cnt_q <= '0;
                    if (w_cnt_q == w_max_q) begin
                        w_cnt_q <= '0;
                        h_cnt_q <= (h_cnt_q == h_max_q) ? '0 : h_cnt_q + 1'b1;
                    end else begin
                        w_cnt_q <= w_cnt_q + 1'b1;
                    end
                end else begin
                    d_cnt_q <= d_cnt_q + 1'b1;
                end
            end
        end
    end

    assign wr_val  = wr_val_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;

`ifdef IMAGE_WRITE_LAST_CHECK_EN
    logic err_q;

    // Sticky framing flag; informational only, completion is decided by the count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (accept && (image_last != last_beat)) begin
            err_q <= 1'b1;
        end else if (next_take) begin
            err_q <= 1'b0;
        end
    end

    assign err = err_q;
`else
    logic unused_last;

    assign unused_last = image_last;
    assign err         = 1'b0;
`endif

endmodule
